dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters with a valid/ready handshake.
  - Port 0: CPU load/store path.
  - Port 1: loader/debug port, which fills or inspects memory while the CPU runs or stalls.
- Round-robin arbitration, with a bounded burst lock for port 1.
- Tracks the fixed memory read latency and routes the single response back to the winning port.
- Sits between the CPU datapath (ALU address, RegRD2 write data, ByteSelect/MemExtend) and DATA_MEMORY.

Parameters:
- MEM_LAT, 1, cycles from acceptance to valid read data / response (>=1).
- MAX_LOCK, 8, max consecutive port-1 grants while port 0 is waiting (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid[1:0]  in  2  request valid, per port.
- req_ready[1:0]  out  2  request accepted when valid&ready.
- req_addr0, req_addr1  in  32  byte address (DATA_BUS).
- req_we[1:0]  in  2  1=store, 0=load.
- req_wdata0, req_wdata1  in  32  store data.
- req_bsel0, req_bsel1  in  byte_format  access size.
- req_sext[1:0]  in  2  load sign-extend.
- lock1  in  1  port 1 requests burst priority.
- rsp_valid[1:0]  out  2  one-cycle response pulse.
- rsp_rdata  out  32  load data; valid when any rsp_valid bit is set.
- mem_a  out  32  memory address.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_bsel  out  byte_format  to DATA_MEMORY ByteSelect.
- mem_sext  out  1  to DATA_MEMORY SignExtend.
- mem_rd  in  32  memory read data.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - req_ready=0, rsp_valid=0, mem_we=0, mem_a/mem_wd/rsp_rdata=0.
  - State IDLE, last_grant=1 (so port 0 wins first), lock_cnt=0.
  - Any in-flight response is discarded; no rsp_valid pulse follows reset.
- States:
  - IDLE: free.
  - BUSY: counter cnt counts MEM_LAT down to 0.
- Ready:
  - req_ready[g] is high only for the port g the arbiter selects this cycle.
  - Selection is allowed in IDLE, or in BUSY when cnt==1 (the response cycle), giving back-to-back throughput of one transaction per MEM_LAT cycles.
  - At most one ready bit is high in any cycle.
- Selection when both ports are valid:
  - Default: the port != last_grant.
  - Lock override: if lock1=1, last_grant=1 and lock_cnt<MAX_LOCK, port 1 is selected.
  - Starvation guard: when lock_cnt==MAX_LOCK, port 0 is forced.
- Single valid port: that port is selected.
- No valid port: no selection; ready stays low.
- Acceptance at cycle N (valid&ready on port g):
  - mem_a/mem_wd/mem_bsel/mem_sext take port g's fields combinationally in cycle N.
  - A registered copy holds them stable through cycle N+MEM_LAT.
  - mem_we=req_we[g] in cycle N only, so a store commits on the edge ending cycle N.
  - Update last_grant=g, load cnt=MEM_LAT, go to BUSY.
- lock_cnt:
  - Increments on each port-1 grant while req_valid[0]=1, saturating at MAX_LOCK.
  - Cleared on any port-0 grant, and on any cycle with lock1=0.
- Response:
  - rsp_valid[g]=1 in cycle N+MEM_LAT, for exactly one cycle, for loads and stores alike.
  - rsp_rdata=mem_rd in that cycle for loads; 0 for stores.
- Counter:
  - cnt decrements each BUSY cycle.
  - At the response cycle, return to IDLE unless a new acceptance occurs in the same cycle, in which case reload cnt and stay in BUSY.
- Requesters must hold their fields stable while valid&!ready. The arbiter never drops a valid request; a losing port sees ready=0.
- lock1 is ignored unless req_valid[1] is high.
- Address/data widths pass through unchanged; no alignment checks here (DATA_MEMORY handles byte lanes).

Decomposition:
- types_pkg additions:
  - arb_state_t enum {IDLE, BUSY}.
  - MEM_REQ packed struct {addr, we, wdata, bsel, sext}, so each port is one bus.
- Reuse DATA_BUS and byte_format from types_pkg.
- One natural sub-module: rr_pick2. Combinational 2-way round-robin picker with lock/starvation override; inputs valid[1:0], last_grant, lock_ok; output onehot grant.
- The FSM, counters and hold registers live in dmem_arbiter.

Test Plan:
- Reset mid-load: accept port-0 load at addr 0x10, assert rst in the next cycle -> rsp_valid stays 0 for MEM_LAT+2 cycles; req_ready=0 while rst is high.
- Port-0 store then load: store 0xDEADBEEF to 0x20, then load 0x20 (MEM_LAT=1) -> rsp_valid[0] pulses on consecutive cycles; second rsp_rdata=0xDEADBEEF; mem_we high exactly 1 cycle.
- Simultaneous contention: both ports valid continuously, lock1=0, after reset -> grants alternate 0,1,0,1; each port gets exactly 4 of 8 grants.
- Burst lock with starvation: MAX_LOCK=3, lock1=1, both valid, port 1 granted first -> grants 1,1,1,0,1,1,1,0; lock_cnt never exceeds 3.
- Latency: MEM_LAT=3, single port-1 load accepted at cycle N -> req_ready low N+1..N+2; rsp_valid[1] at N+3; mem_a stable N..N+3; a new request is accepted in N+3.
- Idle: no valid for 10 cycles -> req_ready=0, mem_we=0, rsp_valid=0 throughout.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: bus width, access size,
// arbiter state encoding and the per-port request bundle.
package dmem_arbiter_pkg;

    typedef logic [31:0] DATA_BUS;

    typedef enum logic [1:0] {
        BF_BYTE = 2'd0,
        BF_HALF = 2'd1,
        BF_WORD = 2'd2,
        BF_RSVD = 2'd3
    } byte_format;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        DATA_BUS    addr;
        logic       we;
        DATA_BUS    wdata;
        byte_format bsel;
        logic       sext;
    } MEM_REQ;

    // Bundle one port's loose request fields into a single bus
    function automatic MEM_REQ pack_req(input DATA_BUS    a,
                                        input logic       we,
                                        input DATA_BUS    wd,
                                        input byte_format bs,
                                        input logic       se);
        MEM_REQ r;
        r.addr  = a;
        r.we    = we;
        r.wdata = wd;
        r.bsel  = bs;
        r.sext  = se;
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker. Port 1 may keep the grant while the caller
// reports its burst lock as still within budget; otherwise the port that
// did not win last time is preferred.
module rr_pick2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    input  logic       i_lock_ok,
    output logic [1:0] o_grant
);

    // One-hot grant from valid set, last winner and lock permission
    always_comb begin
        o_grant = '0;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11: begin
                if (i_last_grant && i_lock_ok)
                    o_grant = 2'b10;
                else if (i_last_grant)
                    o_grant = 2'b01;
                else
                    o_grant = 2'b10;
            end
            default: o_grant = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares DATA_MEMORY between the CPU load/store path
// (port 0) and the loader/debug port (port 1). One transaction in flight,
// fixed read latency MEM_LAT, response routed back to the winning port.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  DATA_BUS    req_addr0,
    input  DATA_BUS    req_addr1,
    input  logic [1:0] req_we,
    input  DATA_BUS    req_wdata0,
    input  DATA_BUS    req_wdata1,
    input  byte_format req_bsel0,
    input  byte_format req_bsel1,
    input  logic [1:0] req_sext,
    input  logic       lock1,
    output logic [1:0] rsp_valid,
    output DATA_BUS    rsp_rdata,
    output DATA_BUS    mem_a,
    output logic       mem_we,
    output DATA_BUS    mem_wd,
    output byte_format mem_bsel,
    output logic       mem_sext,
    input  DATA_BUS    mem_rd
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int LW = $clog2(MAX_LOCK + 1);

    arb_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_last_grant;
    logic [LW-1:0]   r_lock_cnt;
    MEM_REQ          r_hold;

    MEM_REQ          w_req0;
    MEM_REQ          w_req1;
    MEM_REQ          w_sel_req;
    MEM_REQ          w_bus;
    logic            w_resp;
    logic            w_sel_ok;
    logic            w_lock_ok;
    logic [1:0]      w_pick;
    logic            w_acc;
    logic            w_acc_port;

    assign w_req0 = pack_req(req_addr0, req_we[0], req_wdata0, req_bsel0, req_sext[0]);
    assign w_req1 = pack_req(req_addr1, req_we[1], req_wdata1, req_bsel1, req_sext[1]);

    // Response cycle is the last BUSY cycle; a new pick may overlap it
    assign w_resp    = (r_state == BUSY) && (r_cnt == CW'(1));
    assign w_sel_ok  = !rst && ((r_state == IDLE) || w_resp);
    assign w_lock_ok = lock1 && req_valid[1] && (r_lock_cnt < LW'(MAX_LOCK));

    rr_pick2 u_pick (
        .i_valid      (req_valid),
        .i_last_grant (r_last_grant),
        .i_lock_ok    (w_lock_ok),
        .o_grant      (w_pick)
    );

    assign req_ready  = w_sel_ok ? w_pick : 2'b00;
    assign w_acc      = |req_ready;
    assign w_acc_port = req_ready[1];
    assign w_sel_req  = w_acc_port ? w_req1 : w_req0;

    // Accepting cycle drives the new request straight through; afterwards
    // the held copy keeps the memory inputs stable until the response.
    assign w_bus    = w_acc ? w_sel_req : r_hold;
    assign mem_a    = w_bus.addr;
    assign mem_wd   = w_bus.wdata;
    assign mem_bsel = w_bus.bsel;
    assign mem_sext = w_bus.sext;
    assign mem_we   = w_acc && w_sel_req.we;

    // last_grant always names the in-flight transaction's port
    assign rsp_valid = w_resp ? {r_last_grant, ~r_last_grant} : 2'b00;
    assign rsp_rdata = (w_resp && !r_hold.we) ? mem_rd : '0;

    // Transaction FSM: accept, count the memory latency, release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_hold       <= '0;
        end else if (w_acc) begin
            r_state      <= BUSY;
            r_cnt        <= CW'(MEM_LAT);
            r_last_grant <= w_acc_port;
            r_hold       <= w_sel_req;
        end else if (r_state == BUSY) begin
            if (r_cnt == CW'(1)) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt - CW'(1);
            end
        end
    end

    // Burst budget for port 1 while port 0 is kept waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_cnt <= '0;
        end else if (!lock1 || (w_acc && !w_acc_port)) begin
            r_lock_cnt <= '0;
        end else if (w_acc && w_acc_port && req_valid[0] &&
                     (r_lock_cnt < LW'(MAX_LOCK))) begin
            r_lock_cnt <= r_lock_cnt + LW'(1);
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a response scoreboard and a simple
// word-addressed memory that returns read data MEM_LAT cycles later.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int LAT  = 2;
    localparam int LOCK = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    DATA_BUS    req_addr0, req_addr1;
    logic [1:0] req_we;
    DATA_BUS    req_wdata0, req_wdata1;
    byte_format req_bsel0, req_bsel1;
    logic [1:0] req_sext;
    logic       lock1;
    logic [1:0] rsp_valid;
    DATA_BUS    rsp_rdata;
    DATA_BUS    mem_a;
    logic       mem_we;
    DATA_BUS    mem_wd;
    byte_format mem_bsel;
    logic       mem_sext;
    DATA_BUS    mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_LAT(LAT), .MAX_LOCK(LOCK)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_we     (req_we),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_bsel0  (req_bsel0),
        .req_bsel1  (req_bsel1),
        .req_sext   (req_sext),
        .lock1      (lock1),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_a      (mem_a),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_bsel   (mem_bsel),
        .mem_sext   (mem_sext),
        .mem_rd     (mem_rd)
    );

    // Memory: write on the accepting edge, read data pipelined LAT stages
    DATA_BUS mem     [0:63]    = '{default: '0};
    DATA_BUS rd_pipe [0:LAT-1] = '{default: '0};
    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:2]] <= mem_wd;
        rd_pipe[0] <= mem[mem_a[7:2]];
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rd = rd_pipe[LAT-1];

    typedef struct {
        int      port;
        DATA_BUS data;
        int      due;
    } exp_t;

    exp_t    sb[$];
    int      glog[$];
    DATA_BUS ref_mem [0:63] = '{default: '0};
    int      total = 0;
    int      bad   = 0;
    int      cyc   = 0;
    int      we_cnt = 0;
    DATA_BUS last_rd0 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: per-cycle protocol checks and scoreboard push/pop
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                chk("rst_ready", 32'(req_ready), 32'd0);
                chk("rst_rsp", 32'(rsp_valid), 32'd0);
                chk("rst_we", 32'(mem_we), 32'd0);
            end else begin
                logic [1:0] acc;
                chk("ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
                if (mem_we) we_cnt++;
                if (rsp_valid != 2'b00) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("rsp_port", 32'(rsp_valid), 32'd1 << e.port);
                        chk("rsp_data", rsp_rdata, e.data);
                        chk("rsp_cycle", 32'(cyc), 32'(e.due));
                        if (e.port == 0) last_rd0 = rsp_rdata;
                    end
                end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                    chk("rsp_missing", 32'(rsp_valid), 32'd1 << sb[0].port);
                    void'(sb.pop_front());
                end
                acc = req_valid & req_ready;
                if (acc != 2'b00) begin
                    int      p;
                    DATA_BUS a, d;
                    logic    w;
                    exp_t    e;
                    p = acc[1] ? 1 : 0;
                    a = p ? req_addr1  : req_addr0;
                    d = p ? req_wdata1 : req_wdata0;
                    w = req_we[p];
                    chk("acc_mem_a", mem_a, a);
                    chk("acc_mem_we", 32'(mem_we), 32'(w));
                    chk("acc_mem_wd", mem_wd, d);
                    chk("acc_bsel", 32'(mem_bsel), p ? 32'(BF_HALF) : 32'(BF_WORD));
                    chk("acc_sext", 32'(mem_sext), 32'(p));
                    e.port = p;
                    e.due  = cyc + LAT;
                    if (w) begin
                        e.data = '0;
                        ref_mem[a[7:2]] = d;
                    end else begin
                        e.data = ref_mem[a[7:2]];
                    end
                    sb.push_back(e);
                    glog.push_back(p);
                end else begin
                    chk("noacc_mem_we", 32'(mem_we), 32'd0);
                end
            end
        end
    end

    // Issue one request on port p (called just after a rising edge)
    task automatic send(input int p, input logic we, input DATA_BUS a, input DATA_BUS d);
        bit got = 0;
        if (p == 0) begin req_addr0 = a; req_wdata0 = d; end
        else        begin req_addr1 = a; req_wdata1 = d; end
        req_we[p]    = we;
        req_valid[p] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[p]) begin got = 1; break; end
        end
        chk("send_accepted", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_grants(input int n);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (glog.size() >= n) break;
        end
        #1;
        req_valid = 2'b00;
        chk("grant_count", 32'(glog.size()), 32'(n));
    endtask

    int exp_burst [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

    initial begin
        int ones;
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_sext = 2'b10; lock1 = 1'b0;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        req_bsel0 = BF_WORD; req_bsel1 = BF_HALF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp", 32'(rsp_valid), 32'd0);
        chk("reset_mem_a", mem_a, 32'd0);
        chk("reset_mem_wd", mem_wd, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;

        // Reset mid-load discards the pending response
        send(0, 1'b0, 32'h10, 32'h0);
        rst = 1'b1;
        req_valid[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_ready", 32'(req_ready), 32'd0);
            chk("midrst_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 2'b00;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            chk("postrst_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Port-0 store then load of the same word
        we_cnt = 0;
        send(0, 1'b1, 32'h20, 32'hDEADBEEF);
        send(0, 1'b0, 32'h20, 32'h0);
        drain();
        chk("store_we_cycles", 32'(we_cnt), 32'd1);
        chk("load_after_store", last_rd0, 32'hDEADBEEF);

        // Contention without lock alternates 0,1,0,1...
        do_reset();
        glog.delete();
        lock1 = 1'b0;
        req_addr0 = 32'h20; req_addr1 = 32'h40; req_we = 2'b00;
        req_valid = 2'b11;
        wait_grants(8);
        drain();
        ones = 0;
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            chk("rr_order", 32'(glog[i]), 32'(i % 2));
            ones += glog[i];
        end
        chk("rr_port1_share", 32'(ones), 32'd4);

        // Burst lock with starvation guard
        do_reset();
        glog.delete();
        lock1 = 1'b1;
        req_valid = 2'b11;
        wait_grants(8);
        lock1 = 1'b0;
        drain();
        for (int i = 0; i < 8 && i < glog.size(); i++)
            chk("burst_order", 32'(glog[i]), 32'(exp_burst[i]));

        // Latency: ready low during the wait, memory inputs held, re-accept
        // exactly at the response cycle
        begin
            bit got = 0;
            do_reset();
            req_addr1 = 32'h40; req_we[1] = 1'b0;
            req_valid[1] = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (req_ready[1]) begin got = 1; break; end
            end
            chk("lat_first_acc", 32'(got), 32'd1);
            @(posedge clk); #1;
            req_addr1 = 32'h44;
            for (int i = 1; i < LAT; i++) begin
                @(negedge clk);
                chk("lat_ready_low", 32'(req_ready), 32'd0);
                chk("lat_mem_a_hold", mem_a, 32'h40);
            end
            @(negedge clk);
            chk("lat_reaccept", 32'(req_ready), 32'd2);
            @(posedge clk); #1;
            req_valid = 2'b00;
            drain();
        end

        // Idle: nothing moves with no valid requests
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(req_ready), 32'd0);
            chk("idle_we", 32'(mem_we), 32'd0);
            chk("idle_rsp", 32'(rsp_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
